// File: rtl/dag3_preimage_enum_if.sv
// ----------------------------------------------------------------------------
// dag3_preimage_enum_if
// Purpose : Groups the control, pair-stream handshake and status signals of
//           dag3_preimage_enum into one bundle.
// Signals : start/target   - request a sweep for a given result value
//           busy/done      - sweep status; done is a one-cycle pulse
//           pair_valid/pair_ready/pair_a/pair_b - matching-pair stream
//           match_count    - pairs accepted in the current or last sweep
// Modports: master - the requester/consumer side (drives start, target,
//                    pair_ready)
//           slave  - the enumerator itself
// ----------------------------------------------------------------------------
interface dag3_preimage_enum_if #(
  parameter int BITS = 2
);
  logic              start;
  logic [BITS-1:0]   target;
  logic              busy;
  logic              pair_valid;
  logic              pair_ready;
  logic [BITS-1:0]   pair_a;
  logic [BITS-1:0]   pair_b;
  logic              done;
  logic [2*BITS:0]   match_count;

  modport master (
    output start, target, pair_ready,
    input  busy, pair_valid, pair_a, pair_b, done, match_count
  );

  modport slave (
    input  start, target, pair_ready,
    output busy, pair_valid, pair_a, pair_b, done, match_count
  );
endinterface

// File: rtl/dag3_preimage_enum.sv
// ----------------------------------------------------------------------------
// dag3_preimage_enum
// Purpose : Inverts the three-level add/subtract DAG. For a latched target it
//           walks every operand pair (x, y) in index order, evaluates the DAG
//           literally (no algebraic shortcut, so the block also exercises the
//           DAG equations) and streams out each pair whose result matches,
//           stalling under downstream back-pressure.
// Ports   : clock - rising-edge clock
//           reset - asynchronous, active-high reset
//           bus   - dag3_preimage_enum_if.slave (start/target in, pair stream
//                   out with valid/ready, busy/done/match_count status)
// ----------------------------------------------------------------------------
module dag3_preimage_enum #(
  parameter int BITS = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  dag3_preimage_enum_if.slave   bus
);

  localparam int IW = 2 * BITS;
  localparam logic [IW-1:0] LAST_IDX = {IW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [IW-1:0]    r_idx;
  logic [BITS-1:0]  r_tgt;
  logic [BITS-1:0]  r_pair_a;
  logic [BITS-1:0]  r_pair_b;
  logic [IW:0]      r_match_count;

  // Operands split from the sweep index: x is the high half, y the low half.
  logic [BITS-1:0]  w_x;
  logic [BITS-1:0]  w_y;
  logic [BITS-1:0]  w_c;
  logic [BITS-1:0]  w_a;
  logic [BITS-1:0]  w_b;
  logic [BITS-1:0]  w_d;
  logic [BITS-1:0]  w_f;
  logic             w_hit;
  logic             w_last;

  assign w_x = r_idx[IW-1:BITS];
  assign w_y = r_idx[BITS-1:0];

  // DAG evaluated term by term; each node is truncated to BITS so the
  // wrap-around behaviour of the forward datapath is reproduced exactly.
  assign w_c = w_x + w_y;
  assign w_a = w_y + w_c;
  assign w_b = w_x - w_c;
  assign w_d = w_b + w_y;
  assign w_f = w_a + w_b + w_c + w_d;

  assign w_hit  = (w_f == r_tgt);
  assign w_last = (r_idx == LAST_IDX);

  // NOTE: the state register uses an asynchronous reset and non-blocking
  // assignments; all decisions live in the combinational block below.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: next state is defaulted to the current state first so no path
  // through the case leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next_state = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_hit) begin
          w_next_state = S_HOLD;
        end else if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_HOLD: begin
        // A match on the final index finishes straight from HOLD.
        if (bus.pair_ready) begin
          w_next_state = w_last ? S_DONE : S_SCAN;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Sweep index, latched target, presented pair and accepted-pair counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx         <= '0;
      r_tgt         <= '0;
      r_pair_a      <= '0;
      r_pair_b      <= '0;
      r_match_count <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_tgt         <= bus.target;
            r_idx         <= '0;
            r_match_count <= '0;
          end
        end
        S_SCAN: begin
          if (w_hit) begin
            // idx is left in place; it advances only after the handshake.
            r_pair_a <= w_x;
            r_pair_b <= w_y;
          end else if (!w_last) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.pair_ready) begin
            r_match_count <= r_match_count + 1'b1;
            if (!w_last) begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs are decoded from state only, so start and pair_ready
  // never reach an output combinationally.
  assign bus.busy        = (r_state == S_SCAN) || (r_state == S_HOLD);
  assign bus.pair_valid  = (r_state == S_HOLD);
  assign bus.done        = (r_state == S_DONE);
  assign bus.pair_a      = r_pair_a;
  assign bus.pair_b      = r_pair_b;
  assign bus.match_count = r_match_count;

endmodule

// File: tb/tb_dag3_preimage_enum.sv
// ----------------------------------------------------------------------------
// tb_dag3_preimage_enum
// Self-checking bench for dag3_preimage_enum (BITS = 2). Expected pairs come
// from a plain-integer evaluation of the DAG over all operand pairs; sweep
// lengths are derived from the index count, number of matches and stall
// cycles. Directed sweeps are followed by randomized targets and ready
// patterns, then an asynchronous reset in the middle of a sweep.
// ----------------------------------------------------------------------------
module tb_dag3_preimage_enum;

  localparam int BITS = 2;
  localparam int M    = 1 << BITS;
  localparam int NIDX = 1 << (2 * BITS);

  typedef struct packed {
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
  } pair_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  dag3_preimage_enum_if #(.BITS(BITS)) bus ();

  dag3_preimage_enum #(.BITS(BITS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int    n_cmp = 0;
  int    n_bad = 0;
  pair_t exp_q [$];
  pair_t got_q [$];
  logic [3:0] spec0 [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Forward DAG with ordinary integer arithmetic reduced modulo 2^BITS.
  function automatic int dag_f(input int x, input int y);
    int c, a, b, d;
    c = (x + y) % M;
    a = (y + c) % M;
    b = (((x - c) % M) + M) % M;
    d = (b + y) % M;
    return (a + b + c + d) % M;
  endfunction

  task automatic build_model(input int t);
    pair_t p;
    exp_q.delete();
    for (int x = 0; x < M; x++) begin
      for (int y = 0; y < M; y++) begin
        if (dag_f(x, y) == t) begin
          p.a = x[BITS-1:0];
          p.b = y[BITS-1:0];
          exp_q.push_back(p);
        end
      end
    end
  endtask

  // Runs one full sweep from IDLE and returns in the first IDLE cycle after
  // DONE, so consecutive calls start back-to-back.
  task automatic run_sweep(input int t, input int ready_pct, input int stall_first,
                           input bit poke_start, input int exp_done_edge);
    int         n;
    int         nexp;
    int         stalls;
    int         first_stalls;
    bit         prev_valid;
    bit         rdy;
    logic [BITS-1:0] pa, pb;
    pair_t      hp;
    pair_t      gp;

    build_model(t);
    nexp         = exp_q.size();
    stalls       = 0;
    first_stalls = 0;
    got_q.delete();

    bus.start      = 1'b1;
    bus.target     = t[BITS-1:0];
    bus.pair_ready = 1'b0;
    tick();
    bus.start = 1'b0;
    check("start_busy", bus.busy, 1);
    check("start_count", bus.match_count, 0);

    for (n = 1; n <= 2000; n++) begin
      prev_valid = bus.pair_valid;
      pa         = bus.pair_a;
      pb         = bus.pair_b;
      rdy        = ($urandom_range(99) < ready_pct);
      if (prev_valid && got_q.size() == 0 && first_stalls < stall_first) begin
        rdy = 1'b0;
        first_stalls++;
      end
      bus.pair_ready = rdy;
      if (poke_start && n == 5) begin
        bus.start  = 1'b1;
        bus.target = BITS'((t + 2) % M);
      end
      tick();
      bus.start = 1'b0;

      if (prev_valid && rdy) begin
        check("pair_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          hp = exp_q.pop_front();
          check("pair_a", pa, hp.a);
          check("pair_b", pb, hp.b);
        end
        gp.a = pa;
        gp.b = pb;
        got_q.push_back(gp);
      end else if (prev_valid) begin
        stalls++;
        check("hold_valid", bus.pair_valid, 1);
        check("hold_a", bus.pair_a, pa);
        check("hold_b", bus.pair_b, pb);
      end

      if (bus.done) break;
      check("busy", bus.busy, 1);
    end

    check("done_seen", bus.done, 1);
    check("done_edge", n, NIDX + nexp + stalls);
    if (exp_done_edge > 0) check("done_edge_spec", n, exp_done_edge);
    check("match_count", bus.match_count, nexp);
    check("model_drained", exp_q.size(), 0);
    check("done_busy", bus.busy, 0);
    check("done_valid", bus.pair_valid, 0);

    bus.pair_ready = 1'b0;
    tick();
    check("done_pulse", bus.done, 0);
    check("count_hold", bus.match_count, nexp);
    check("idle_busy", bus.busy, 0);
  endtask

  initial begin
    int nv;
    int k;

    spec0[0] = 4'h0; spec0[1] = 4'h2; spec0[2] = 4'h5; spec0[3] = 4'h7;
    spec0[4] = 4'h8; spec0[5] = 4'hA; spec0[6] = 4'hD; spec0[7] = 4'hF;

    bus.start      = 1'b0;
    bus.target     = '0;
    bus.pair_ready = 1'b0;

    // Reset state
    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.pair_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_a", bus.pair_a, 0);
    check("rst_b", bus.pair_b, 0);
    check("rst_count", bus.match_count, 0);
    @(negedge clock);
    reset = 1'b0;
    tick();
    tick();
    check("idle_no_start", bus.busy, 0);

    // No preimages
    run_sweep(1, 100, 0, 1'b0, 16);
    run_sweep(3, 100, 0, 1'b0, 16);

    // Full enumeration in index order
    run_sweep(0, 100, 0, 1'b0, 24);
    check("enum_size", got_q.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("enum_pair%0d", i), got_q[i], spec0[i]);

    // Back-pressure on the first pair
    run_sweep(2, 100, 3, 1'b0, 27);
    check("bp_first_pair", got_q[0], 4'h1);
    check("bp_size", got_q.size(), 8);

    // Start while busy is ignored
    run_sweep(2, 100, 0, 1'b1, 24);
    check("poke_size", got_q.size(), 8);
    check("poke_last", got_q[got_q.size()-1], 4'hE);

    // Randomized targets and ready patterns, back-to-back
    for (int r = 0; r < 6; r++) begin
      run_sweep(int'($urandom_range(M - 1)), int'($urandom_range(90, 30)), 0, 1'b0, 0);
    end

    // Asynchronous reset during the third HOLD of a target-0 sweep
    bus.start      = 1'b1;
    bus.target     = '0;
    bus.pair_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    nv = 0;
    for (k = 0; k < 200 && nv < 3; k++) begin
      if (bus.pair_valid) nv++;
      if (nv < 3) tick();
    end
    check("third_hold_reached", nv, 3);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_valid", bus.pair_valid, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_a", bus.pair_a, 0);
    check("mid_rst_b", bus.pair_b, 0);
    check("mid_rst_count", bus.match_count, 0);
    bus.pair_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_busy", bus.busy, 0);
      check("post_rst_valid", bus.pair_valid, 0);
      check("post_rst_done", bus.done, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
